// File: rtl/clk_branch_gate_pkg.sv
// clk_branch_gate_pkg: shared types and helpers for the gated-branch enable controller.
//   state_e : FSM encoding (OFF=0, WAKE=1, ON=2, IDLE=3)
//   clog2   : ceiling log2, used to size the shared down-counter
package clk_branch_gate_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/clk_branch_gate_cnt.sv
// clk_branch_gate_cnt: loadable down-counter that saturates at zero.
//   clk, rst   : clock, async active-high reset
//   load_i     : load load_val_i (wins over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one, holds at zero
//   value_o    : current count
//   zero_o     : count is zero
module clk_branch_gate_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign zero_o  = (cnt_q == '0);
    assign value_o = cnt_q;

    always_comb cnt_d = load_i ? load_val_i : (dec_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/clk_branch_gate_ctrl.sv
// clk_branch_gate_ctrl: reference-counted enable controller for one ICG-gated clock branch.
//   clk, rst : free-running source clock, async active-high reset
//   req_i    : per-requester clock request (level)
//   te_i     : test enable, forces en_o high without touching the FSM
//   en_o     : registered enable to the ICG E pin
//   gnt_o    : registered per-requester grant, branch clock is running for it
//   clk_on_o : registered, branch is in ON or IDLE
module clk_branch_gate_ctrl
    import clk_branch_gate_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WAKE_CYC = 4,
    parameter int IDLE_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             te_i,
    output logic             en_o,
    output logic [N_REQ-1:0] gnt_o,
    output logic             clk_on_o
);

    localparam int MAX_CYC = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
    localparam int CNT_W   = clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);

    state_e           state_q, state_d;
    logic             any_req, cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_ld_val, cnt_val_unused;
    logic             en_q, clk_on_q;
    logic [N_REQ-1:0] gnt_q;

    assign any_req = |req_i;

    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_ld_val = WAKE_LD;
        cnt_dec    = 1'b0;
        case (state_q)
            ST_OFF: if (any_req) begin
                state_d  = ST_WAKE;
                cnt_load = 1'b1;
            end
            // Requests are ignored while waking; the wake always completes.
            ST_WAKE: if (cnt_zero) state_d = ST_ON;
                     else          cnt_dec = 1'b1;
            ST_ON: if (!any_req) begin
                state_d    = ST_IDLE;
                cnt_load   = 1'b1;
                cnt_ld_val = IDLE_LD;
            end
            // Clock is still running in IDLE, so a returning request skips the wake.
            default: if (any_req)       state_d = ST_ON;
                     else if (cnt_zero) state_d = ST_OFF;
                     else               cnt_dec = 1'b1;
        endcase
    end

    clk_branch_gate_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_ld_val),
        .dec_i      (cnt_dec),
        .value_o    (cnt_val_unused),
        .zero_o     (cnt_zero)
    );

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= ST_OFF;
            en_q     <= 1'b0;
            gnt_q    <= '0;
            clk_on_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= (state_d != ST_OFF) || te_i;
            gnt_q    <= req_i & {N_REQ{state_d == ST_ON}};
            clk_on_q <= (state_d == ST_ON) || (state_d == ST_IDLE);
        end

    assign en_o     = en_q;
    assign gnt_o    = gnt_q;
    assign clk_on_o = clk_on_q;

endmodule

// File: tb/tb_clk_branch_gate_ctrl.sv
// tb_clk_branch_gate_ctrl: directed and randomized checks against a timestamp-based reference model.
module tb_clk_branch_gate_ctrl;

    localparam int N    = 4;
    localparam int WAKE = 4;
    localparam int IDLE = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         te  = 1'b0;
    logic         en;
    logic [N-1:0] gnt;
    logic         clk_on;

    int vectors = 0;
    int miscompares = 0;

    // Model: branch enabled flag, edge counter, edge at which grants may begin,
    // and the last edge the branch was known to be in use.
    bit           m_enabled;
    int           m_t;
    int           m_grant_from;
    int           m_mark;
    logic         m_en;
    logic [N-1:0] m_gnt;
    logic         m_on;

    clk_branch_gate_ctrl #(.N_REQ(N), .WAKE_CYC(WAKE), .IDLE_CYC(IDLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .te_i     (te),
        .en_o     (en),
        .gnt_o    (gnt),
        .clk_on_o (clk_on)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_enabled    = 1'b0;
        m_t          = 0;
        m_grant_from = 0;
        m_mark       = 0;
        m_en         = 1'b0;
        m_gnt        = '0;
        m_on         = 1'b0;
    endtask

    task automatic model_edge();
        bit on;
        m_t++;
        if (!m_enabled) begin
            if (req != '0) begin
                m_enabled    = 1'b1;
                m_grant_from = m_t + WAKE;
            end
        end else if (m_t >= m_grant_from) begin
            if (m_t == m_grant_from || req != '0) m_mark = m_t;
            else if (m_t - m_mark > IDLE)          m_enabled = 1'b0;
        end
        on     = m_enabled && (m_t >= m_grant_from);
        m_en   = m_enabled || te;
        m_gnt  = on ? req : '0;
        m_on   = on;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        req = 4'b1111;
        te  = 1'b1;
        repeat (2) begin
            tick();
            vectors++;
            if ({en, gnt, clk_on} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_hold: en=%b gnt=%b clk_on=%b want 0/0000/0", en, gnt, clk_on);
            end
        end
        #2;
        rst = 1'b0;
        req = '0;
        te  = 1'b0;
        tick();
        vectors++;
        if ({en, gnt, clk_on} !== {m_en, m_gnt, m_on} || en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: en=%b gnt=%b clk_on=%b want %b/%b/%b", en, gnt, clk_on, m_en, m_gnt, m_on);
        end
    endtask

    task automatic test_wake_latency();
        req = 4'b0001;
        for (int k = 0; k <= WAKE; k++) begin
            tick();
            vectors++;
            if ({en, gnt, clk_on} !== {m_en, m_gnt, m_on} || en !== 1'b1 ||
                gnt !== ((k == WAKE) ? 4'b0001 : 4'b0000)) begin
                miscompares++;
                $display("FAIL wake_k%0d: en=%b gnt=%b clk_on=%b want %b/%b/%b", k, en, gnt, clk_on, m_en, m_gnt, m_on);
            end
        end
    endtask

    task automatic test_sharing();
        req = 4'b0101;
        tick();
        vectors++;
        if (gnt !== 4'b0101 || en !== 1'b1 || {en, gnt, clk_on} !== {m_en, m_gnt, m_on}) begin
            miscompares++;
            $display("FAIL share_add: en=%b gnt=%b want 1/0101", en, gnt);
        end
        repeat (3) tick();
        req = 4'b0100;
        tick();
        vectors++;
        if (gnt !== 4'b0100 || en !== 1'b1 || clk_on !== 1'b1) begin
            miscompares++;
            $display("FAIL share_drop: en=%b gnt=%b clk_on=%b want 1/0100/1", en, gnt, clk_on);
        end
    endtask

    task automatic test_hysteresis();
        req = '0;
        for (int k = 0; k <= IDLE; k++) begin
            tick();
            vectors++;
            if ({en, gnt, clk_on} !== {m_en, m_gnt, m_on} || gnt !== 4'b0 ||
                en !== (k < IDLE) || clk_on !== (k < IDLE)) begin
                miscompares++;
                $display("FAIL hyst_k%0d: en=%b gnt=%b clk_on=%b want %b/0000/%b", k, en, gnt, clk_on, k < IDLE, k < IDLE);
            end
        end
    endtask

    task automatic bring_on(input logic [N-1:0] r);
        req = r;
        repeat (WAKE + 2) tick();
    endtask

    task automatic test_idle_rescue();
        bring_on(4'b0010);
        req = '0;
        repeat (IDLE) begin
            tick();
            vectors++;
            if (en !== 1'b1 || {en, gnt, clk_on} !== {m_en, m_gnt, m_on}) begin
                miscompares++;
                $display("FAIL rescue_wait: en=%b gnt=%b clk_on=%b want %b/%b/%b", en, gnt, clk_on, m_en, m_gnt, m_on);
            end
        end
        req = 4'b1000;
        tick();
        vectors++;
        if (gnt !== 4'b1000 || en !== 1'b1 || clk_on !== 1'b1) begin
            miscompares++;
            $display("FAIL rescue_edge: en=%b gnt=%b clk_on=%b want 1/1000/1", en, gnt, clk_on);
        end
    endtask

    task automatic test_reset_mid_on();
        bring_on(4'b0011);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({en, gnt, clk_on} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_reset: en=%b gnt=%b clk_on=%b want 0/0000/0", en, gnt, clk_on);
        end
        tick();
        #2;
        rst = 1'b0;
        for (int k = 0; k <= WAKE; k++) begin
            tick();
            vectors++;
            if ({en, gnt, clk_on} !== {m_en, m_gnt, m_on} || en !== 1'b1 ||
                gnt !== ((k == WAKE) ? 4'b0011 : 4'b0000)) begin
                miscompares++;
                $display("FAIL rewake_k%0d: en=%b gnt=%b want 1/%b", k, en, gnt, (k == WAKE) ? 4'b0011 : 4'b0000);
            end
        end
        req = '0;
        repeat (IDLE + 2) tick();
    endtask

    task automatic test_te();
        req = '0;
        te  = 1'b1;
        tick();
        vectors++;
        if (en !== 1'b1 || gnt !== 4'b0 || clk_on !== 1'b0) begin
            miscompares++;
            $display("FAIL te_force: en=%b gnt=%b clk_on=%b want 1/0000/0", en, gnt, clk_on);
        end
        req = 4'b0010;
        for (int k = 0; k <= WAKE; k++) begin
            tick();
            vectors++;
            if ({en, gnt, clk_on} !== {m_en, m_gnt, m_on} ||
                gnt !== ((k == WAKE) ? 4'b0010 : 4'b0000)) begin
                miscompares++;
                $display("FAIL te_wake_k%0d: en=%b gnt=%b clk_on=%b want %b/%b/%b", k, en, gnt, clk_on, m_en, m_gnt, m_on);
            end
        end
        te  = 1'b0;
        req = '0;
        repeat (IDLE + 2) tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(3) == 0)
                req = ($urandom_range(2) == 0) ? '0 : N'($urandom);
            if ($urandom_range(15) == 0) te = ~te;
            tick();
            vectors++;
            if ({en, gnt, clk_on} !== {m_en, m_gnt, m_on}) begin
                miscompares++;
                $display("FAIL random_%0d: en=%b gnt=%b clk_on=%b want %b/%b/%b", k, en, gnt, clk_on, m_en, m_gnt, m_on);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wake_latency();
        test_sharing();
        test_hysteresis();
        test_idle_rescue();
        req = '0;
        repeat (IDLE + 2) tick();
        test_reset_mid_on();
        test_te();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
